// File: rtl/obb_reg_file.sv
// Multi-entry oriented-bounding-box state file: parallel load, registered read port and a
// sequential pos/angle integrator. Optional macro OBB_REG_FILE_GRAVITY_EN adds per-step gravity on vel_y.
module obb_reg_file #(
  parameter int unsigned N_BODIES    = 4,
  parameter int unsigned POS_W       = 20,
  parameter int unsigned VEL_W       = 12,
  parameter int unsigned PREC        = 8,
  parameter int unsigned DIM_W       = 8,
  parameter int unsigned ANGLE_W     = 10,
  parameter int unsigned OMEGA_W     = 8,
  parameter int unsigned X_INIT      = 32,
  parameter int unsigned Y_INIT      = 32,
  parameter int unsigned X_SPACING   = 40,
  parameter int unsigned WIDTH_INIT  = 10,
  parameter int unsigned HEIGHT_INIT = 10,
  parameter int          GRAVITY     = 1,
  localparam int unsigned IDX_W      = $clog2(N_BODIES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [IDX_W-1:0]   ld_idx,
  input  logic [POS_W-1:0]   ld_pos_x,
  input  logic [POS_W-1:0]   ld_pos_y,
  input  logic [VEL_W-1:0]   ld_vel_x,
  input  logic [VEL_W-1:0]   ld_vel_y,
  input  logic [DIM_W-1:0]   ld_width,
  input  logic [DIM_W-1:0]   ld_height,
  input  logic [ANGLE_W-1:0] ld_angle,
  input  logic [OMEGA_W-1:0] ld_omega,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [POS_W-1:0]   rd_pos_x,
  output logic [POS_W-1:0]   rd_pos_y,
  output logic [VEL_W-1:0]   rd_vel_x,
  output logic [VEL_W-1:0]   rd_vel_y,
  output logic [DIM_W-1:0]   rd_width,
  output logic [DIM_W-1:0]   rd_height,
  output logic [ANGLE_W-1:0] rd_angle,
  output logic [OMEGA_W-1:0] rd_omega,
  input  logic               step,
  output logic               busy,
  output logic               done
);

  typedef struct packed {
    logic [POS_W-1:0]   pos_x;
    logic [POS_W-1:0]   pos_y;
    logic [VEL_W-1:0]   vel_x;
    logic [VEL_W-1:0]   vel_y;
    logic [DIM_W-1:0]   width;
    logic [DIM_W-1:0]   height;
    logic [ANGLE_W-1:0] angle;
    logic [OMEGA_W-1:0] omega;
  } body_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int unsigned      PX_W     = POS_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BODIES - 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_BODIES);

  // Elaboration-time parameter sanity
  if (N_BODIES < 2) begin : g_bad_n
    $error("obb_reg_file: N_BODIES must be at least 2");
  end
  if (GRAVITY >= 2 ** (VEL_W - 1) || GRAVITY < -(2 ** (VEL_W - 1))) begin : g_bad_gravity
    $error("obb_reg_file: GRAVITY does not fit in VEL_W");
  end

  body_t            ents [N_BODIES];
  body_t            rd_q;
  body_t            ld_body;
  body_t            integ;
  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             busy_nxt, done_nxt;
  logic             ld_ok, rd_ok, run_wr;

  function automatic body_t init_body(input int unsigned i);
    body_t b;
    b        = '0;
    b.pos_x  = POS_W'((X_INIT + i * X_SPACING) << PREC);
    b.pos_y  = POS_W'(Y_INIT << PREC);
    b.width  = DIM_W'(WIDTH_INIT);
    b.height = DIM_W'(HEIGHT_INIT);
    return b;
  endfunction

  // Two guard bits so both underflow and overflow are visible before clamping
  function automatic logic [POS_W-1:0] sat_pos(input logic [POS_W-1:0] p,
                                               input logic [VEL_W-1:0] v);
    logic signed [PX_W-1:0] s;
    s = $signed({2'b00, p}) + PX_W'($signed(v));
    if (s[PX_W-1])     return '0;
    else if (s[POS_W]) return '1;
    else               return s[POS_W-1:0];
  endfunction

`ifdef OBB_REG_FILE_GRAVITY_EN
  function automatic logic [VEL_W-1:0] sat_vel(input logic [VEL_W-1:0] v);
    logic signed [VEL_W:0] s;
    s = (VEL_W + 1)'($signed(v)) + (VEL_W + 1)'(GRAVITY);
    if (s[VEL_W] != s[VEL_W-1])
      return s[VEL_W] ? {1'b1, {(VEL_W-1){1'b0}}} : {1'b0, {(VEL_W-1){1'b1}}};
    else
      return s[VEL_W-1:0];
  endfunction
`endif

  assign ld_body = {ld_pos_x, ld_pos_y, ld_vel_x, ld_vel_y,
                    ld_width, ld_height, ld_angle, ld_omega};
  assign ld_ok   = load && ({1'b0, ld_idx} < N_EXT);
  assign rd_ok   = {1'b0, rd_idx} < N_EXT;
  // A same-cycle load to the entry under integration takes priority
  assign run_wr  = (state == S_RUN) && !(ld_ok && (ld_idx == idx));

  always_comb begin
    integ       = ents[idx];
    integ.pos_x = sat_pos(ents[idx].pos_x, ents[idx].vel_x);
    integ.pos_y = sat_pos(ents[idx].pos_y, ents[idx].vel_y);
    integ.angle = ents[idx].angle + ANGLE_W'($signed(ents[idx].omega));
`ifdef OBB_REG_FILE_GRAVITY_EN
    integ.vel_y = sat_vel(ents[idx].vel_y);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_BODIES; i++) ents[i] <= init_body(i);
      rd_q <= '0;
    end else begin
      if (run_wr) ents[idx] <= integ;
      if (ld_ok)  ents[ld_idx] <= ld_body;
      rd_q <= rd_ok ? ents[rd_idx] : '0;
    end
  end

  assign rd_pos_x  = rd_q.pos_x;
  assign rd_pos_y  = rd_q.pos_y;
  assign rd_vel_x  = rd_q.vel_x;
  assign rd_vel_y  = rd_q.vel_y;
  assign rd_width  = rd_q.width;
  assign rd_height = rd_q.height;
  assign rd_angle  = rd_q.angle;
  assign rd_omega  = rd_q.omega;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Sweep sequencer; busy follows the next state so it is high exactly in RUN/DONE
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (step) begin
          state_nxt = S_RUN;
          idx_nxt   = '0;
        end
      end
      S_RUN: begin
        if (idx == LAST_IDX) state_nxt = S_DONE;
        else                 idx_nxt   = idx + 1'b1;
      end
      S_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_obb_reg_file.sv
// Randomised self-checking bench for obb_reg_file against an array-based reference model.
// Define OBB_REG_FILE_GRAVITY_EN on both files to cover the gravity build.
module tb_obb_reg_file;
  localparam int N       = 4;
  localparam int IDX_W   = $clog2(N);
  localparam int POS_W   = 20;
  localparam int VEL_W   = 12;
  localparam int DIM_W   = 8;
  localparam int ANGLE_W = 10;
  localparam int OMEGA_W = 8;
  localparam int GRAV    = 1;
  localparam int VW      = 2 * POS_W + 2 * VEL_W + 2 * DIM_W + ANGLE_W + OMEGA_W;
  localparam int POS_MAX = (1 << POS_W) - 1;

  logic               clk = 1'b0;
  logic               reset, load, step;
  logic [IDX_W-1:0]   ld_idx, rd_idx;
  logic [POS_W-1:0]   ld_pos_x, ld_pos_y, rd_pos_x, rd_pos_y;
  logic [VEL_W-1:0]   ld_vel_x, ld_vel_y, rd_vel_x, rd_vel_y;
  logic [DIM_W-1:0]   ld_width, ld_height, rd_width, rd_height;
  logic [ANGLE_W-1:0] ld_angle, rd_angle;
  logic [OMEGA_W-1:0] ld_omega, rd_omega;
  logic               busy, done;
  logic [VW-1:0]      rd_vec;

  int n_checks = 0;
  int n_fail   = 0;
  int m_px[N], m_py[N], m_vx[N], m_vy[N], m_w[N], m_h[N], m_ang[N], m_om[N];

  obb_reg_file #(.N_BODIES(N), .POS_W(POS_W), .VEL_W(VEL_W), .PREC(8), .DIM_W(DIM_W),
                 .ANGLE_W(ANGLE_W), .OMEGA_W(OMEGA_W), .X_INIT(32), .Y_INIT(32),
                 .X_SPACING(40), .WIDTH_INIT(10), .HEIGHT_INIT(10), .GRAVITY(GRAV)) dut (
    .clk(clk), .reset(reset), .load(load), .ld_idx(ld_idx),
    .ld_pos_x(ld_pos_x), .ld_pos_y(ld_pos_y), .ld_vel_x(ld_vel_x), .ld_vel_y(ld_vel_y),
    .ld_width(ld_width), .ld_height(ld_height), .ld_angle(ld_angle), .ld_omega(ld_omega),
    .rd_idx(rd_idx), .rd_pos_x(rd_pos_x), .rd_pos_y(rd_pos_y), .rd_vel_x(rd_vel_x),
    .rd_vel_y(rd_vel_y), .rd_width(rd_width), .rd_height(rd_height), .rd_angle(rd_angle),
    .rd_omega(rd_omega), .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign rd_vec = {rd_pos_x, rd_pos_y, rd_vel_x, rd_vel_y, rd_width, rd_height, rd_angle, rd_omega};

  // ---------------- reference model ----------------
  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [VW-1:0] exp_vec(int i);
    return {POS_W'(m_px[i]), POS_W'(m_py[i]), VEL_W'(m_vx[i]), VEL_W'(m_vy[i]),
            DIM_W'(m_w[i]), DIM_W'(m_h[i]), ANGLE_W'(m_ang[i]), OMEGA_W'(m_om[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_px[i] = (32 + 40 * i) * 256; m_py[i] = 32 * 256;
      m_vx[i] = 0; m_vy[i] = 0; m_w[i] = 10; m_h[i] = 10; m_ang[i] = 0; m_om[i] = 0;
    end
  endtask

  // One sweep; entry 'skip' is left untouched (its integration lost to a load)
  task automatic model_step(int skip);
    for (int i = 0; i < N; i++) begin
      if (i != skip) begin
        m_px[i]  = clampi(m_px[i] + m_vx[i], 0, POS_MAX);
        m_py[i]  = clampi(m_py[i] + m_vy[i], 0, POS_MAX);
        m_ang[i] = (m_ang[i] + m_om[i]) & ((1 << ANGLE_W) - 1);
`ifdef OBB_REG_FILE_GRAVITY_EN
        m_vy[i]  = clampi(m_vy[i] + GRAV, -(1 << (VEL_W - 1)), (1 << (VEL_W - 1)) - 1);
`endif
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_load(int i, int px, int py, int vx, int vy, int w, int h, int a, int o);
    load = 1'b1; ld_idx = IDX_W'(i);
    ld_pos_x = POS_W'(px); ld_pos_y = POS_W'(py); ld_vel_x = VEL_W'(vx); ld_vel_y = VEL_W'(vy);
    ld_width = DIM_W'(w); ld_height = DIM_W'(h); ld_angle = ANGLE_W'(a); ld_omega = OMEGA_W'(o);
  endtask

  task automatic do_load(int i, int px, int py, int vx, int vy, int w, int h, int a, int o);
    drive_load(i, px, py, vx, vy, w, h, a, o);
    tick();
    load = 1'b0;
    m_px[i] = px; m_py[i] = py; m_vx[i] = vx; m_vy[i] = vy;
    m_w[i] = w; m_h[i] = h; m_ang[i] = a; m_om[i] = o;
  endtask

  task automatic read_entry(int i, output logic [VW-1:0] v);
    rd_idx = IDX_W'(i);
    tick();
    v = rd_vec;
  endtask

  // Request a sweep and count cycles after the accepting edge until done (bounded)
  task automatic run_step(output int n);
    step = 1'b1; tick(); step = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [VW-1:0] v;
    int exp_px[N];
    exp_px = '{8192, 18432, 28672, 38912};
    reset = 1'b1; #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
    n_checks++; if (rd_vec !== '0) begin n_fail++; $display("FAIL reset_rd: got %h exp 0", rd_vec); end
    tick(); tick(); reset = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      read_entry(i, v);
      n_checks++; if (v !== exp_vec(i)) begin n_fail++; $display("FAIL reset_entry%0d: got %h exp %h", i, v, exp_vec(i)); end
      n_checks++; if (int'(rd_pos_x) != exp_px[i]) begin n_fail++; $display("FAIL reset_pos_x%0d: got %0d exp %0d", i, rd_pos_x, exp_px[i]); end
    end
  endtask

  task automatic test_load_step();
    logic [VW-1:0] v;
    int n;
    do_load(2, 28672, 8192, 256, 0, 10, 10, 1, -3);
    step = 1'b1; tick(); step = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL step_busy: got %b exp 1", busy); end
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    model_step(-1);
    n_checks++; if (n != N + 1) begin n_fail++; $display("FAIL step_latency: got %0d exp %0d", n, N + 1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL step_busy_end: got %b exp 0", busy); end
    for (int i = 0; i < N; i++) begin
      read_entry(i, v);
      n_checks++; if (v !== exp_vec(i)) begin n_fail++; $display("FAIL step_entry%0d: got %h exp %h", i, v, exp_vec(i)); end
      if (i == 2) begin
        n_checks++; if (rd_pos_x !== 20'd28928) begin n_fail++; $display("FAIL step_pos_x2: got %0d exp 28928", rd_pos_x); end
        n_checks++; if (rd_angle !== 10'd1022) begin n_fail++; $display("FAIL step_angle2: got %0d exp 1022", rd_angle); end
      end
    end
  endtask

  task automatic test_saturation();
    logic [VW-1:0] v;
    int n;
    do_load(0, 100, 8192, -256, 0, 10, 10, 0, 0);
    do_load(1, POS_MAX + 1 - 10, 8192, 100, 0, 10, 10, 0, 0);
    run_step(n);
    model_step(-1);
    n_checks++; if (n != N + 1) begin n_fail++; $display("FAIL sat_latency: got %0d exp %0d", n, N + 1); end
    read_entry(0, v);
    n_checks++; if (rd_pos_x !== 20'd0) begin n_fail++; $display("FAIL sat_low: got %0d exp 0", rd_pos_x); end
    read_entry(1, v);
    n_checks++; if (rd_pos_x !== 20'd1048575) begin n_fail++; $display("FAIL sat_high: got %0d exp 1048575", rd_pos_x); end
    for (int i = 0; i < N; i++) begin
      read_entry(i, v);
      n_checks++; if (v !== exp_vec(i)) begin n_fail++; $display("FAIL sat_entry%0d: got %h exp %h", i, v, exp_vec(i)); end
    end
  endtask

  task automatic test_collision();
    logic [VW-1:0] v;
    int dones = 0;
    step = 1'b1; tick();   // accepting edge; step stays high into the sweep
    tick();                // entry 0 integrated; entry 1 is next
    drive_load(1, 5000, m_py[1], m_vx[1], m_vy[1], m_w[1], m_h[1], m_ang[1], m_om[1]);
    tick();
    load = 1'b0; step = 1'b0;
    for (int c = 0; c < 15; c++) begin tick(); if (done === 1'b1) dones++; end
    model_step(1);
    m_px[1] = 5000;
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL coll_done_pulses: got %0d exp 1", dones); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL coll_busy: got %b exp 0", busy); end
    for (int i = 0; i < N; i++) begin
      read_entry(i, v);
      n_checks++; if (v !== exp_vec(i)) begin n_fail++; $display("FAIL coll_entry%0d: got %h exp %h", i, v, exp_vec(i)); end
      if (i == 1) begin
        n_checks++; if (rd_pos_x !== 20'd5000) begin n_fail++; $display("FAIL coll_pos_x1: got %0d exp 5000", rd_pos_x); end
      end
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] v;
    int n, px, py;
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        case ($urandom_range(0, 3))
          0:       px = int'($urandom_range(0, 2000));
          1:       px = POS_MAX - int'($urandom_range(0, 2000));
          default: px = int'($urandom_range(0, POS_MAX));
        endcase
        py = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2000)) : int'($urandom_range(0, POS_MAX));
        do_load(int'($urandom_range(0, N - 1)), px, py,
                int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)) - 128);
      end
      if ($urandom_range(0, 3) != 0) begin
        run_step(n);
        model_step(-1);
        n_checks++; if (n != N + 1) begin n_fail++; $display("FAIL rand_latency it%0d: got %0d exp %0d", it, n, N + 1); end
      end
      for (int i = 0; i < N; i++) begin
        read_entry(i, v);
        n_checks++; if (v !== exp_vec(i)) begin n_fail++; $display("FAIL rand_entry it%0d e%0d: got %h exp %h", it, i, v, exp_vec(i)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] v;
    do_load(0, 50000, 9000, 300, -200, 20, 30, 5, 7);
    step = 1'b1; tick(); step = 1'b0;
    tick();                // second RUN cycle
    reset = 1'b1; #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b exp 0", busy); end
    n_checks++; if (rd_vec !== '0) begin n_fail++; $display("FAIL mid_reset_rd: got %h exp 0", rd_vec); end
    tick(); reset = 1'b0;
    model_reset();
    read_entry(0, v);
    n_checks++; if (v !== exp_vec(0)) begin n_fail++; $display("FAIL mid_reset_entry0: got %h exp %h", v, exp_vec(0)); end
    n_checks++; if (rd_pos_x !== 20'd8192) begin n_fail++; $display("FAIL mid_reset_pos_x0: got %0d exp 8192", rd_pos_x); end
    tick(); tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_idle: got busy=%b done=%b exp 0/0", busy, done); end
  endtask

`ifdef OBB_REG_FILE_GRAVITY_EN
  task automatic test_gravity();
    logic [VW-1:0] v;
    int n;
    for (int s = 0; s < 3; s++) begin run_step(n); model_step(-1); end
    read_entry(0, v);
    n_checks++; if (rd_vel_y !== 12'd3) begin n_fail++; $display("FAIL grav_vel_y: got %0d exp 3", rd_vel_y); end
    n_checks++; if (rd_pos_y !== 20'd8195) begin n_fail++; $display("FAIL grav_pos_y: got %0d exp 8195", rd_pos_y); end
    n_checks++; if (v !== exp_vec(0)) begin n_fail++; $display("FAIL grav_entry0: got %h exp %h", v, exp_vec(0)); end
  endtask
`endif

  initial begin
    reset = 1'b0; load = 1'b0; step = 1'b0; ld_idx = '0; rd_idx = '0;
    ld_pos_x = '0; ld_pos_y = '0; ld_vel_x = '0; ld_vel_y = '0;
    ld_width = '0; ld_height = '0; ld_angle = '0; ld_omega = '0;
    test_reset();
    test_load_step();
    test_saturation();
    test_collision();
    test_random();
    test_reset_mid();
`ifdef OBB_REG_FILE_GRAVITY_EN
    test_gravity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
